cache_controller_wb: RTL and testbench

//  Parametrised successor cache controller between the ARM MEM stage and the SRAM controller.

---
 rtl/cache_controller_wb_pkg.sv | 18 +
 rtl/cache_controller_wb_write_buffer_fifo.sv | 55 +++++
 rtl/cache_controller_wb.sv | 152 +++++++++++++++
 tb/tb_cache_controller_wb.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_wb_pkg.sv
// Shared definitions for the write-buffered cache controller: FSM encoding and
// the default base address subtracted before cache indexing.
package cache_controller_wb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MISS_WAIT = 2'b01,
    FILL      = 2'b10
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

  // Byte address of the word containing addr.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/cache_controller_wb_write_buffer_fifo.sv
// Circular posted-write buffer. Pointers wrap naturally; a push is refused when
// full even if a pop happens in the same cycle.
module write_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array carries no reset; count and pointers alone define
  // which entries are valid, so clearing the data would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cache_controller_wb.sv
// Cache controller between the MEM stage and SRAM: read hits in zero wait states,
// line fills on miss, stores posted through a write buffer that drains to SRAM.
module cache_controller_wb
  import cache_controller_wb_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          LINE_WORDS   = 2,
  parameter int          CACHE_ADDR_W = 17,
  parameter logic [31:0] ADDR_BASE    = ADDR_BASE_DEFAULT,
  parameter int          WB_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MEM_R_EN,
  input  logic                         MEM_W_EN,
  input  logic [31:0]                  address,
  input  logic [DATA_W-1:0]            writeData,
  output logic                         ready,
  output logic [DATA_W-1:0]            readData,
  input  logic                         Cache_Hit,
  input  logic [DATA_W-1:0]            CacheReadData,
  output logic                         Cache_RE,
  output logic                         Cache_WE,
  output logic                         checkInvalidation,
  output logic [CACHE_ADDR_W-1:0]      CacheAddress,
  output logic [LINE_WORDS*DATA_W-1:0] CacheWriteData,
  input  logic                         SRAM_Ready,
  output logic                         SRAM_RE,
  output logic                         SRAM_WE,
  output logic [31:0]                  SRAM_Adress,
  output logic [DATA_W-1:0]            SRAM_Write_Data,
  input  logic [LINE_WORDS*DATA_W-1:0] SRAM_Read_Data
);

  localparam int OFF_W          = $clog2(LINE_WORDS);
  localparam int LINE_BYTE_BITS = OFF_W + 2;
  localparam int ENTRY_W        = 32 + DATA_W;
  localparam int CNT_W          = $clog2(WB_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        word_addr;
  logic [OFF_W-1:0]   word_sel;
  logic               wb_push;
  logic               wb_pop;
  logic               wb_full;
  logic               wb_empty;
  logic [ENTRY_W-1:0] wb_din;
  logic [ENTRY_W-1:0] wb_dout;
  logic [CNT_W-1:0]   wb_count;
  logic               drain_active;

  assign word_addr    = word_align(address);
  assign CacheAddress = CACHE_ADDR_W'((word_addr - ADDR_BASE) >> 2);
  assign word_sel     = CacheAddress[OFF_W-1:0];
  assign wb_din       = {word_addr, writeData};

  // The drain shares the SRAM port with fills, so it yields during FILL.
  assign drain_active = !rst && !wb_empty && (state != FILL);
  assign wb_pop       = drain_active && SRAM_Ready;

  write_buffer_fifo #(
    .DEPTH (WB_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_write_buffer (
    .clk   (clk),
    .rst   (rst),
    .push  (wb_push),
    .pop   (wb_pop),
    .din   (wb_din),
    .dout  (wb_dout),
    .full  (wb_full),
    .empty (wb_empty),
    .count (wb_count)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt         = state;
    ready             = 1'b0;
    readData          = '0;
    Cache_RE          = 1'b0;
    Cache_WE          = 1'b0;
    checkInvalidation = 1'b0;
    CacheWriteData    = '0;
    SRAM_RE           = 1'b0;
    SRAM_WE           = 1'b0;
    SRAM_Adress       = '0;
    SRAM_Write_Data   = '0;
    wb_push           = 1'b0;

    if (rst) begin
      ready = !(MEM_R_EN || MEM_W_EN);
    end else begin
      if (drain_active) begin
        SRAM_WE         = 1'b1;
        SRAM_Adress     = wb_dout[ENTRY_W-1:DATA_W];
        SRAM_Write_Data = wb_dout[DATA_W-1:0];
      end

      unique case (state)
        IDLE: begin
          if (MEM_R_EN) begin
            Cache_RE = 1'b1;
            if (Cache_Hit) begin
              ready    = 1'b1;
              readData = CacheReadData;
            end else begin
              state_nxt = (wb_count == '0) ? FILL : MISS_WAIT;
            end
          end else if (MEM_W_EN) begin
            if (!wb_full) begin
              wb_push           = 1'b1;
              checkInvalidation = 1'b1;
              ready             = 1'b1;
            end
          end else begin
            ready = 1'b1;
          end
        end

        // Older posted writes must reach SRAM before the line is refetched.
        MISS_WAIT: begin
          if (wb_count == '0) state_nxt = FILL;
        end

        FILL: begin
          SRAM_RE     = 1'b1;
          SRAM_Adress = {address[31:LINE_BYTE_BITS], {LINE_BYTE_BITS{1'b0}}};
          if (SRAM_Ready) begin
            Cache_WE       = 1'b1;
            CacheWriteData = SRAM_Read_Data;
            ready          = 1'b1;
            readData       = SRAM_Read_Data[word_sel*DATA_W +: DATA_W];
            state_nxt      = IDLE;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

endmodule

// File: tb/tb_cache_controller_wb.sv
// Self-checking bench: single-cycle vector table plus multi-cycle sequences, with
// scoreboards for SRAM write order and load data.
module tb_cache_controller_wb;

  localparam int DATA_W       = 32;
  localparam int LINE_WORDS   = 2;
  localparam int CACHE_ADDR_W = 17;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         MEM_R_EN;
  logic                         MEM_W_EN;
  logic [31:0]                  address;
  logic [DATA_W-1:0]            writeData;
  logic                         ready;
  logic [DATA_W-1:0]            readData;
  logic                         Cache_Hit;
  logic [DATA_W-1:0]            CacheReadData;
  logic                         Cache_RE;
  logic                         Cache_WE;
  logic                         checkInvalidation;
  logic [CACHE_ADDR_W-1:0]      CacheAddress;
  logic [LINE_WORDS*DATA_W-1:0] CacheWriteData;
  logic                         SRAM_Ready;
  logic                         SRAM_RE;
  logic                         SRAM_WE;
  logic [31:0]                  SRAM_Adress;
  logic [DATA_W-1:0]            SRAM_Write_Data;
  logic [LINE_WORDS*DATA_W-1:0] SRAM_Read_Data;

  always #5 clk = ~clk;

  cache_controller_wb dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_R_EN          (MEM_R_EN),
    .MEM_W_EN          (MEM_W_EN),
    .address           (address),
    .writeData         (writeData),
    .ready             (ready),
    .readData          (readData),
    .Cache_Hit         (Cache_Hit),
    .CacheReadData     (CacheReadData),
    .Cache_RE          (Cache_RE),
    .Cache_WE          (Cache_WE),
    .checkInvalidation (checkInvalidation),
    .CacheAddress      (CacheAddress),
    .CacheWriteData    (CacheWriteData),
    .SRAM_Ready        (SRAM_Ready),
    .SRAM_RE           (SRAM_RE),
    .SRAM_WE           (SRAM_WE),
    .SRAM_Adress       (SRAM_Adress),
    .SRAM_Write_Data   (SRAM_Write_Data),
    .SRAM_Read_Data    (SRAM_Read_Data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        r_en;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] crd;
    logic        exp_ready;
    logic        exp_cre;
    logic        exp_inval;
    logic [31:0] exp_rdata;
    logic [16:0] exp_caddr;
  } vec_t;

  localparam int NV = 9;

  wr_t         wq[$];
  logic [31:0] rq[$];
  vec_t        vecs[NV];
  int          n_vec     = 0;
  int          n_err     = 0;
  int          n_drained = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // Runs every cycle at the falling edge: SRAM write order and load data scoreboards.
  task automatic monitor();
    wr_t         e;
    logic [31:0] r;
    if (SRAM_WE && SRAM_RE) check("sram_overlap", {63'd0, SRAM_WE & SRAM_RE}, 64'd0);
    if (SRAM_WE && SRAM_Ready) begin
      if (wq.size() == 0) begin
        fail_now("wb_unexpected", $sformatf("SRAM write to %h, expected none", SRAM_Adress));
      end else begin
        e = wq.pop_front();
        check("wb_addr", SRAM_Adress, e.addr);
        check("wb_data", SRAM_Write_Data, e.data);
        n_drained++;
      end
    end
    if (MEM_R_EN && ready) begin
      if (rq.size() == 0) begin
        fail_now("rd_unexpected", $sformatf("load completed with %h, expected none", readData));
      end else begin
        r = rq.pop_front();
        check("rd_data", readData, r);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    repeat (n) begin
      at_neg();
      to_next();
    end
  endtask

  task automatic post_write(input logic [31:0] a, input logic [31:0] d, input logic track);
    MEM_R_EN  = 1'b0;
    MEM_W_EN  = 1'b1;
    address   = a;
    writeData = d;
    if (track) wq.push_back('{addr: a & ~32'd3, data: d});
    at_neg();
    check("wr_ready", ready, 1);
    check("wr_inval", checkInvalidation, 1);
    to_next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  we_count;
    int  done_idx;
    bit  done;
    bit  saw_re;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         17'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001, 17'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_040C, 32'h0,         1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 17'h3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 17'hF00};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 17'h1FEFF};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 17'h1FFFF};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0403, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         17'h0};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0408, 32'h0000_0011, 1'b1, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0, 32'hAAAA_5555, 17'h2};
    vecs[8] = '{1'b0, 1'b1, 32'h0000_07FC, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         17'hFF};

    rst            = 1'b1;
    MEM_R_EN       = 1'b0;
    MEM_W_EN       = 1'b0;
    address        = 32'h400;
    writeData      = '0;
    Cache_Hit      = 1'b0;
    CacheReadData  = '0;
    SRAM_Ready     = 1'b0;
    SRAM_Read_Data = '0;

    // Reset state
    to_next();
    at_neg();
    check("rst_ready", ready, 1);
    check("rst_rdata", readData, 0);
    check("rst_cache_re", Cache_RE, 0);
    check("rst_cache_we", Cache_WE, 0);
    check("rst_inval", checkInvalidation, 0);
    check("rst_sram_re", SRAM_RE, 0);
    check("rst_sram_we", SRAM_WE, 0);
    check("rst_cwdata", CacheWriteData, 0);
    check("rst_swdata", SRAM_Write_Data, 0);
    to_next();
    rst = 1'b0;

    // Single-cycle vectors from IDLE with an empty buffer
    for (int i = 0; i < NV; i++) begin
      MEM_R_EN      = vecs[i].r_en;
      MEM_W_EN      = vecs[i].w_en;
      address       = vecs[i].addr;
      writeData     = vecs[i].wdata;
      Cache_Hit     = vecs[i].hit;
      CacheReadData = vecs[i].crd;
      SRAM_Ready    = 1'b0;
      if (vecs[i].r_en) rq.push_back(vecs[i].exp_rdata);
      else if (vecs[i].w_en) wq.push_back('{addr: vecs[i].addr & ~32'd3, data: vecs[i].wdata});
      at_neg();
      check($sformatf("v%0d_ready", i), ready, vecs[i].exp_ready);
      check($sformatf("v%0d_cache_re", i), Cache_RE, vecs[i].exp_cre);
      check($sformatf("v%0d_inval", i), checkInvalidation, vecs[i].exp_inval);
      check($sformatf("v%0d_caddr", i), CacheAddress, vecs[i].exp_caddr);
      check($sformatf("v%0d_sram_re", i), SRAM_RE, 0);
      check($sformatf("v%0d_sram_we", i), SRAM_WE, 0);
      check($sformatf("v%0d_cache_we", i), Cache_WE, 0);
      if (!vecs[i].r_en) check($sformatf("v%0d_rdata", i), readData, vecs[i].exp_rdata);
      to_next();
      Cache_Hit  = 1'b0;
      SRAM_Ready = 1'b1;
      idle_cycles(2);
      SRAM_Ready = 1'b0;
    end
    check("tbl_wq_empty", wq.size(), 0);

    // Read miss, empty buffer, SRAM answers on the third FILL cycle
    SRAM_Read_Data = {32'hB, 32'hA};
    MEM_R_EN       = 1'b1;
    address        = 32'h40C;
    Cache_Hit      = 1'b0;
    rq.push_back(32'hB);
    at_neg();
    check("miss_ready", ready, 0);
    check("miss_cache_re", Cache_RE, 1);
    check("miss_sram_re", SRAM_RE, 0);
    to_next();
    done     = 1'b0;
    we_count = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      SRAM_Ready = (c == 2);
      at_neg();
      check("fill_sram_re", SRAM_RE, 1);
      check("fill_addr", SRAM_Adress, 32'h408);
      check("fill_ready", ready, (c == 2));
      check("fill_cache_we", Cache_WE, (c == 2));
      if (Cache_WE) begin
        we_count++;
        check("fill_line", CacheWriteData, {32'hB, 32'hA});
      end
      if (ready) done = 1'b1;
      to_next();
    end
    if (!done) fail_now("fill_timeout", "fill never completed");
    MEM_R_EN   = 1'b0;
    SRAM_Ready = 1'b0;
    at_neg();
    check("fill_after_we", Cache_WE, 0);
    check("fill_after_re", SRAM_RE, 0);
    to_next();
    check("fill_we_once", we_count, 1);

    // Posted writes fill the buffer; the fifth waits for the first pop
    for (int i = 0; i < 4; i++) post_write(32'h500 + 32'(4 * i), 32'h100 + 32'(i), 1'b1);
    MEM_W_EN  = 1'b1;
    address   = 32'h510;
    writeData = 32'h104;
    at_neg();
    check("full_ready", ready, 0);
    check("full_inval", checkInvalidation, 0);
    check("full_sram_we", SRAM_WE, 1);
    to_next();
    at_neg();
    check("full_ready2", ready, 0);
    to_next();
    SRAM_Ready = 1'b1;
    at_neg();
    check("full_no_bypass", ready, 0);
    to_next();
    SRAM_Ready = 1'b0;
    wq.push_back('{addr: 32'h510, data: 32'h104});
    at_neg();
    check("full_after_pop", ready, 1);
    to_next();
    SRAM_Ready = 1'b1;
    idle_cycles(6);
    SRAM_Ready = 1'b0;
    check("full_drained", wq.size(), 0);

    // Read miss behind three buffered writes
    for (int i = 0; i < 3; i++) post_write(32'h700 + 32'(4 * i), 32'h200 + 32'(i), 1'b1);
    base           = n_drained;
    MEM_W_EN       = 1'b0;
    MEM_R_EN       = 1'b1;
    address        = 32'h600;
    Cache_Hit      = 1'b0;
    SRAM_Read_Data = {32'h2222, 32'h1111};
    rq.push_back(32'h1111);
    at_neg();
    check("mw_ready", ready, 0);
    to_next();
    SRAM_Ready = 1'b1;
    done       = 1'b0;
    saw_re     = 1'b0;
    done_idx   = 0;
    for (int c = 1; c < 20 && !done; c++) begin
      at_neg();
      if (SRAM_RE && !saw_re) begin
        saw_re = 1'b1;
        check("mw_drained_first", n_drained - base, 3);
        check("mw_fill_addr", SRAM_Adress, 32'h600);
      end
      if (ready) begin
        done     = 1'b1;
        done_idx = c;
      end
      to_next();
    end
    if (!done) fail_now("mw_timeout", "miss behind writes never completed");
    check("mw_latency", done_idx, 5);
    MEM_R_EN   = 1'b0;
    SRAM_Ready = 1'b0;

    // Push and pop together at count 2, wrapping the pointers
    post_write(32'h800, 32'h300, 1'b1);
    post_write(32'h804, 32'h301, 1'b1);
    SRAM_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      MEM_W_EN  = 1'b1;
      address   = 32'h810 + 32'(4 * i);
      writeData = 32'h310 + 32'(i);
      wq.push_back('{addr: address, data: writeData});
      at_neg();
      check("pp_ready", ready, 1);
      check("pp_sram_we", SRAM_WE, 1);
      to_next();
    end
    base = n_drained;
    idle_cycles(4);
    check("pp_count_two", n_drained - base, 2);
    at_neg();
    check("pp_empty", SRAM_WE, 0);
    to_next();
    SRAM_Ready = 1'b0;

    // Reset in the middle of a fill
    SRAM_Read_Data = {32'hB, 32'hA};
    MEM_R_EN       = 1'b1;
    address        = 32'h40C;
    Cache_Hit      = 1'b0;
    at_neg();
    to_next();
    at_neg();
    check("rf_in_fill", SRAM_RE, 1);
    to_next();
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    at_neg();
    check("rf_rst_sram_re", SRAM_RE, 0);
    check("rf_rst_ready", ready, 1);
    to_next();
    rst = 1'b0;
    at_neg();
    check("rf_idle_sram_re", SRAM_RE, 0);
    check("rf_idle_cache_we", Cache_WE, 0);
    check("rf_idle_cache_re", Cache_RE, 0);
    check("rf_idle_ready", ready, 1);
    to_next();

    // Reset with two buffered writes discards them
    post_write(32'hA00, 32'h400, 1'b0);
    post_write(32'hA04, 32'h401, 1'b0);
    MEM_W_EN = 1'b0;
    rst      = 1'b1;
    at_neg();
    check("rb_rst_sram_we", SRAM_WE, 0);
    to_next();
    rst        = 1'b0;
    SRAM_Ready = 1'b1;
    at_neg();
    check("rb_cleared", SRAM_WE, 0);
    to_next();
    SRAM_Ready = 1'b0;
    for (int i = 0; i < 4; i++) post_write(32'hB00 + 32'(4 * i), 32'h500 + 32'(i), 1'b1);
    SRAM_Ready = 1'b1;
    idle_cycles(6);
    SRAM_Ready = 1'b0;

    check("end_wq_empty", wq.size(), 0);
    check("end_rq_empty", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
